// File: rtl/addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } addsub_state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder: the whole arithmetic datapath of the serial unit.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract, LSB first, one bit per clock, with valid/ready
// handshakes on both the operand and the result side.
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out
);

  localparam int CW = $clog2(WIDTH);

  addsub_state_t    state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] res_sh;
  logic [WIDTH-1:0] res_cat;
  logic [CW-1:0]    cnt;
  logic             mode_q, carry;
  logic             sum, cout, last, accept;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign last      = (cnt == CW'(WIDTH - 1));
  // Partial result with the current bit on top; becomes the low WIDTH bits of out.
  assign res_cat   = {sum, res_sh};

  full_adder_cell u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (sum),
    .cout (cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      mode_q <= MODE_ADD;
      carry  <= 1'b0;
      cnt    <= '0;
      out    <= '0;
    end else if (accept) begin
      // Subtract is a + ~b + 1: invert b here and seed the carry with 1.
      a_sh   <= a;
      b_sh   <= b ^ {WIDTH{mode}};
      mode_q <= mode;
      carry  <= (mode == MODE_SUB);
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      carry  <= cout;
      cnt    <= cnt + CW'(1);
      res_sh <= res_cat[WIDTH-1:1];
      // out only moves on entry to DONE so it holds the last result meanwhile.
      if (last)
        out <= {(mode_q == MODE_ADD) ? cout : ~cout, res_cat};
    end
  end

endmodule
